// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: branch codes, branch opcode prefix, sequencer
// states and the default halt encoding.
package kgp_risc_pkg;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BLTZ = 3'b010;
    localparam logic [2:0] BR_BZ   = 3'b011;
    localparam logic [2:0] BR_BNZ  = 3'b100;
    localparam logic [2:0] BR_BL   = 3'b101;
    localparam logic [2:0] BR_BCY  = 3'b110;
    localparam logic [2:0] BR_BNCY = 3'b111;

    localparam logic [2:0]  BR_OPC_PREFIX     = 3'b101;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Valid-qualified instruction-memory fetch port; the sequencer is the master.
interface pc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/branch_field_decode.sv
// Combinational extraction of branch code, sign-extended offset and
// pseudo-direct address from an instruction word.
module branch_field_decode
    import kgp_risc_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  branch,
    output logic [31:0] offset,
    output logic [31:0] pda
);

    always_comb begin
        branch = BR_SEQ;
        if (instr[31:29] == BR_OPC_PREFIX) begin
            branch = instr[28:26];
        end
        offset = {{16{instr[15]}}, instr[15:0]};
        pda    = {6'b0, instr[25:0]};
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer for KGP_RISC: holds the PC, fetches over the imem port
// and feeds every branch_mechanism input, consuming its next-PC on ex_done.
module pc_sequencer
    import kgp_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        imem,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic                  ex_done,
    input  logic                  alu_flag_we,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    input  logic                  alu_sign,
    output logic [2:0]            bm_branch,
    output logic [31:0]           bm_offset,
    output logic [31:0]           bm_pda,
    output logic [31:0]           bm_instr4,
    output logic                  bm_carry,
    output logic                  bm_zero,
    output logic                  bm_sign,
    input  logic [31:0]           bm_next,
    output logic [31:0]           pc,
    output logic                  halted
);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic [2:0]  flags_q, flags_d;
    logic [2:0]  dec_branch;
    logic        unused_next_lo;

    // Target addresses are word-aligned, so the low bits of bm_next are dropped.
    assign unused_next_lo = ^bm_next[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        req_d         = req_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        flags_d       = flags_q;

        if (alu_flag_we) begin
            flags_d = {alu_carry, alu_zero, alu_sign};
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem.imem_valid) begin
                    req_d = 1'b0;
                    if (imem.imem_rdata == HALT_WORD) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d       = ST_EXEC;
                        instr_d       = imem.imem_rdata;
                        instr_valid_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    state_d       = ST_FETCH;
                    pc_d          = {bm_next[31:2], 2'b00};
                    req_d         = 1'b1;
                    instr_valid_d = 1'b0;
                end
            end
            ST_HALT: begin
                req_d         = 1'b0;
                instr_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            flags_q       <= 3'b000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            req_q         <= req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            flags_q       <= flags_d;
        end
    end

    branch_field_decode u_decode (
        .instr  (instr_q),
        .branch (dec_branch),
        .offset (bm_offset),
        .pda    (bm_pda)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign bm_branch      = (state_q == ST_EXEC) ? dec_branch : BR_SEQ;
    assign bm_instr4      = pc_q + 32'd4;
    assign bm_carry       = flags_q[2];
    assign bm_zero        = flags_q[1];
    assign bm_sign        = flags_q[0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a RESET_PC=0 instance for fetch/branch/flag
// behaviour and a RESET_PC=0xFFFF_FFFC instance for wrap-around and halt.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;

    pc_sequencer_if mif ();
    logic [31:0] instr, bm_offset, bm_pda, bm_instr4, bm_next, pc;
    logic        instr_valid, ex_done, alu_flag_we, alu_carry, alu_zero, alu_sign;
    logic [2:0]  bm_branch;
    logic        bm_carry, bm_zero, bm_sign, halted;

    pc_sequencer_if wif ();
    logic [31:0] w_instr, w_bm_offset, w_bm_pda, w_bm_instr4, w_bm_next, w_pc;
    logic        w_instr_valid, w_ex_done, w_alu_flag_we;
    logic [2:0]  w_bm_branch;
    logic        w_bm_carry, w_bm_zero, w_bm_sign, w_halted;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .imem(mif),
        .instr(instr), .instr_valid(instr_valid), .ex_done(ex_done),
        .alu_flag_we(alu_flag_we), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .bm_branch(bm_branch), .bm_offset(bm_offset),
        .bm_pda(bm_pda), .bm_instr4(bm_instr4), .bm_carry(bm_carry),
        .bm_zero(bm_zero), .bm_sign(bm_sign), .bm_next(bm_next),
        .pc(pc), .halted(halted)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .HALT_WORD(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem(wif),
        .instr(w_instr), .instr_valid(w_instr_valid), .ex_done(w_ex_done),
        .alu_flag_we(w_alu_flag_we), .alu_carry(1'b0), .alu_zero(1'b0),
        .alu_sign(1'b0), .bm_branch(w_bm_branch), .bm_offset(w_bm_offset),
        .bm_pda(w_bm_pda), .bm_instr4(w_bm_instr4), .bm_carry(w_bm_carry),
        .bm_zero(w_bm_zero), .bm_sign(w_bm_sign), .bm_next(w_bm_next),
        .pc(w_pc), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each vector is fetched and executed on the main instance in order;
    // expected values were worked out by hand from the instruction encodings.
    typedef struct {
        logic [31:0] rdata;
        logic [31:0] next;
        logic [2:0]  exp_branch;
        logic [31:0] exp_offset;
        logic [31:0] exp_pda;
        logic [31:0] exp_instr4;
        logic [31:0] exp_pc_after;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] rdata,
                                 input logic done, input logic [31:0] next);
        mif.imem_valid = valid;
        mif.imem_rdata = rdata;
        ex_done        = done;
        bm_next        = next;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'hA800_FFF0, 32'h0000_0103, 3'b010, 32'hFFFF_FFF0, 32'h0000_FFF0, 32'h0000_0044, 32'h0000_0100};
        vecs[1] = '{32'h2000_1234, 32'h0000_0104, 3'b000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0104, 32'h0000_0104};
        vecs[2] = '{32'hBFFF_8000, 32'h0000_2002, 3'b111, 32'hFFFF_8000, 32'h03FF_8000, 32'h0000_0108, 32'h0000_2000};
        vecs[3] = '{32'hB400_0007, 32'hFFFF_FFFF, 3'b101, 32'h0000_0007, 32'h0000_0007, 32'h0000_2004, 32'hFFFF_FFFC};
        vecs[4] = '{32'h8400_0010, 32'h0000_0200, 3'b000, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_0200};

        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h0000_0005, 1'b0, 32'h0);
        alu_flag_we = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0;
        wif.imem_valid = 1'b0; wif.imem_rdata = 32'h0;
        w_ex_done = 1'b0; w_alu_flag_we = 1'b0; w_bm_next = 32'h0;

        tick(); tick();
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_instr", instr, 32'h0);
        checkOutput("reset_req", {31'b0, mif.imem_req}, 32'h0);
        checkOutput("reset_instr_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("reset_halted", {31'b0, halted}, 32'h0);
        checkOutput("reset_bm_branch", {29'b0, bm_branch}, 32'h0);
        checkOutput("reset_flags", {29'b0, bm_carry, bm_zero, bm_sign}, 32'h0);
        checkOutput("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);

        // Zero-wait fetch straight out of reset.
        rst_n = 1'b1;
        tick();
        checkOutput("t1_req", {31'b0, mif.imem_req}, 32'h1);
        checkOutput("t1_addr0", mif.imem_addr, 32'h0);
        checkOutput("t1_ivalid_fetch", {31'b0, instr_valid}, 32'h0);
        tick();
        checkOutput("t1_ivalid_exec", {31'b0, instr_valid}, 32'h1);
        checkOutput("t1_instr", instr, 32'h0000_0005);
        checkOutput("t1_instr4", bm_instr4, 32'h4);
        checkOutput("t1_branch", {29'b0, bm_branch}, 32'h0);
        applyStimulus(1'b1, 32'h0000_0005, 1'b1, 32'h4);
        tick();
        checkOutput("t1_addr4", mif.imem_addr, 32'h4);
        checkOutput("t1_ivalid_one_cycle", {31'b0, instr_valid}, 32'h0);
        checkOutput("t1_req_again", {31'b0, mif.imem_req}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

        // Three wait states with request and address held.
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2_req_wait%0d", i), {31'b0, mif.imem_req}, 32'h1);
            checkOutput($sformatf("t2_addr_wait%0d", i), mif.imem_addr, 32'h4);
            tick();
        end
        applyStimulus(1'b1, 32'hAC00_0880, 1'b0, 32'h0);
        checkOutput("t2_req_at_valid", {31'b0, mif.imem_req}, 32'h1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t2_ivalid", {31'b0, instr_valid}, 32'h1);
        checkOutput("t2_branch_bz", {29'b0, bm_branch}, 32'h3);
        checkOutput("t2_offset", bm_offset, 32'h0000_0880);
        checkOutput("t2_pda", bm_pda, 32'h0000_0880);
        checkOutput("t2_req_dropped", {31'b0, mif.imem_req}, 32'h0);

        // Flag write coinciding with ex_done: old flags visible this cycle.
        alu_flag_we = 1'b1; alu_zero = 1'b0; alu_sign = 1'b1; alu_carry = 1'b0;
        tick();
        alu_flag_we = 1'b0;
        checkOutput("t3_sign_set", {31'b0, bm_sign}, 32'h1);
        checkOutput("t3_zero_clear", {31'b0, bm_zero}, 32'h0);
        checkOutput("t3_still_exec", {31'b0, instr_valid}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0040);
        alu_flag_we = 1'b1; alu_zero = 1'b1; alu_sign = 1'b1;
        #2;
        checkOutput("t3_zero_old_same_cycle", {31'b0, bm_zero}, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        alu_flag_we = 1'b0;
        checkOutput("t3_zero_new", {31'b0, bm_zero}, 32'h1);
        checkOutput("t3_sign_kept", {31'b0, bm_sign}, 32'h1);
        checkOutput("t3_pc", pc, 32'h0000_0040);
        checkOutput("t3_branch_fetch", {29'b0, bm_branch}, 32'h0);

        // ex_done while fetching must not move the PC.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0999);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t3_exdone_ignored_pc", pc, 32'h0000_0040);
        checkOutput("t3_exdone_ignored_req", {31'b0, mif.imem_req}, 32'h1);

        // Table-driven fetch/execute sequence.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].rdata, 1'b0, 32'h0);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
            checkOutput($sformatf("v%0d_ivalid", i), {31'b0, instr_valid}, 32'h1);
            checkOutput($sformatf("v%0d_branch", i), {29'b0, bm_branch}, {29'b0, vecs[i].exp_branch});
            checkOutput($sformatf("v%0d_offset", i), bm_offset, vecs[i].exp_offset);
            checkOutput($sformatf("v%0d_pda", i), bm_pda, vecs[i].exp_pda);
            checkOutput($sformatf("v%0d_instr4", i), bm_instr4, vecs[i].exp_instr4);
            applyStimulus(1'b0, 32'h0, 1'b1, vecs[i].next);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput($sformatf("v%0d_pc_after", i), pc, vecs[i].exp_pc_after);
            checkOutput($sformatf("v%0d_req_after", i), {31'b0, mif.imem_req}, 32'h1);
        end

        // Wrap-around and halt on the second instance.
        checkOutput("t5_w_addr", wif.imem_addr, 32'hFFFF_FFFC);
        checkOutput("t5_w_req", {31'b0, wif.imem_req}, 32'h1);
        wif.imem_valid = 1'b1; wif.imem_rdata = 32'h0000_0001;
        tick();
        wif.imem_valid = 1'b0;
        checkOutput("t5_w_instr4_wrap", w_bm_instr4, 32'h0);
        checkOutput("t5_w_ivalid", {31'b0, w_instr_valid}, 32'h1);
        w_ex_done = 1'b1; w_bm_next = 32'h0000_0008;
        tick();
        w_ex_done = 1'b0;
        checkOutput("t5_w_pc", w_pc, 32'h0000_0008);
        wif.imem_valid = 1'b1; wif.imem_rdata = 32'hFFFF_FFFF;
        tick();
        wif.imem_valid = 1'b1; wif.imem_rdata = 32'h0000_0022;
        w_ex_done = 1'b1; w_bm_next = 32'h0000_0050;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5_halted%0d", i), {31'b0, w_halted}, 32'h1);
            checkOutput($sformatf("t5_req_low%0d", i), {31'b0, wif.imem_req}, 32'h0);
            checkOutput($sformatf("t5_instr_kept%0d", i), w_instr, 32'h0000_0001);
            checkOutput($sformatf("t5_ivalid_low%0d", i), {31'b0, w_instr_valid}, 32'h0);
            checkOutput($sformatf("t5_pc_kept%0d", i), w_pc, 32'h0000_0008);
            tick();
        end
        wif.imem_valid = 1'b0; w_ex_done = 1'b0;

        // Asynchronous reset while the main instance is executing.
        applyStimulus(1'b1, 32'hA400_0004, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t6_pre_ivalid", {31'b0, instr_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_ivalid", {31'b0, instr_valid}, 32'h0);
        checkOutput("t6_async_pc", pc, 32'h0);
        checkOutput("t6_async_instr", instr, 32'h0);
        checkOutput("t6_async_branch", {29'b0, bm_branch}, 32'h0);
        checkOutput("t6_async_flags", {29'b0, bm_carry, bm_zero, bm_sign}, 32'h0);
        checkOutput("t6_async_req", {31'b0, mif.imem_req}, 32'h0);
        checkOutput("t6_async_w_halted", {31'b0, w_halted}, 32'h0);
        applyStimulus(1'b1, 32'h0000_1234, 1'b1, 32'h0000_0300);
        tick(); tick();
        checkOutput("t6_inflight_ignored", instr, 32'h0);
        checkOutput("t6_held_req", {31'b0, mif.imem_req}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("t6_refetch_req", {31'b0, mif.imem_req}, 32'h1);
        checkOutput("t6_refetch_addr", mif.imem_addr, 32'h0);
        checkOutput("t6_w_refetch_addr", wif.imem_addr, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
